// File: rtl/sysid_info_slave_pkg.sv
// Shared word map, register bit positions and reset values for the
// system-ID information slave.
package sysid_info_slave_pkg;

  // Word offsets on the 3-bit address bus
  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
  localparam logic [2:0] ADDR_CONTROL   = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  // CONTROL bit positions
  localparam int unsigned CTRL_EN_BIT   = 0;
  localparam int unsigned CTRL_CLR_BIT  = 1;
  localparam int unsigned CTRL_LOCK_BIT = 2;

  // STATUS bit positions
  localparam int unsigned STAT_OVF_BIT  = 0;
  localparam int unsigned STAT_PERR_BIT = 1;

  // CONTROL comes out of reset with the counter running, unlocked
  localparam logic [31:0] CTRL_RESET = 32'h0000_0001;

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter with enable, synchronous clear and an
// overflow pulse in the cycle the counter wraps from all-ones to zero.
module sysid_uptime_counter #(
  parameter int unsigned CNT_W = 48
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  // Wrap happens on the edge where an enabled, non-cleared count is all-ones
  assign ovf = en & ~clr & (count == '1);

  // Count state: clear has priority over increment; natural wrap at all-ones
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sysid_info_slave.sv
// Memory-mapped system-ID slave: ID, build timestamp, uptime counter with
// HI-word shadow, scratch register, control and sticky status, behind a
// fully pipelined fixed-latency read path.
module sysid_info_slave
  import sysid_info_slave_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = 32'd7,
  parameter logic [31:0] TIMESTAMP    = 32'd1381349107,
  parameter int unsigned CNT_W        = 48,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  logic             rd_acc;
  logic             wr_acc;
  logic             rw_conflict;
  logic             status_w1c;

  logic [CNT_W-1:0] count;
  logic             cnt_ovf;

  logic [31:0]      shadow_hi;
  logic [31:0]      scratch;
  logic             ctrl_en;
  logic             ctrl_clr;
  logic             ctrl_lock;
  logic             st_ovf;
  logic             st_perr;

  logic [31:0]      rd_mux;
  logic [READ_LATENCY-1:0] vld_pipe;
  logic [31:0]      dat_pipe [READ_LATENCY];

  // A simultaneous read and write performs the read and drops the write
  assign rd_acc      = chipselect & read;
  assign rw_conflict = chipselect & read & write;
  assign wr_acc      = chipselect & write & ~read;
  assign status_w1c  = wr_acc & (address == ADDR_STATUS);

  sysid_uptime_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (ctrl_en),
    .clr     (ctrl_clr),
    .count   (count),
    .ovf     (cnt_ovf)
  );

  // Read mux: register values as they stand before this cycle's write
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_ID:        rd_mux = ID_VALUE;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_UPTIME_LO: rd_mux = count[31:0];
      ADDR_UPTIME_HI: rd_mux = shadow_hi;
      ADDR_SCRATCH:   rd_mux = scratch;
      ADDR_CONTROL: begin
        rd_mux[CTRL_EN_BIT]   = ctrl_en;
        rd_mux[CTRL_LOCK_BIT] = ctrl_lock;
      end
      ADDR_STATUS: begin
        rd_mux[STAT_OVF_BIT]  = st_ovf;
        rd_mux[STAT_PERR_BIT] = st_perr;
      end
      default:        rd_mux = '0;
    endcase
  end

  // Register file: shadow capture, scratch, control and sticky status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_hi <= '0;
      scratch   <= '0;
      ctrl_en   <= CTRL_RESET[CTRL_EN_BIT];
      ctrl_clr  <= CTRL_RESET[CTRL_CLR_BIT];
      ctrl_lock <= CTRL_RESET[CTRL_LOCK_BIT];
      st_ovf    <= 1'b0;
      st_perr   <= 1'b0;
    end else begin
      ctrl_clr <= 1'b0;
      if (rd_acc && (address == ADDR_UPTIME_LO)) begin
        shadow_hi <= 32'(count[CNT_W-1:32]);
      end
      if (wr_acc) begin
        case (address)
          ADDR_SCRATCH: begin
            if (!ctrl_lock) begin
              scratch <= writedata;
            end
          end
          ADDR_CONTROL: begin
            ctrl_en  <= writedata[CTRL_EN_BIT];
            ctrl_clr <= writedata[CTRL_CLR_BIT];
            if (writedata[CTRL_LOCK_BIT]) begin
              ctrl_lock <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // Set beats write-1-to-clear in the same cycle
      st_ovf  <= cnt_ovf | (st_ovf & ~(status_w1c & writedata[STAT_OVF_BIT]));
      st_perr <= rw_conflict | (st_perr & ~(status_w1c & writedata[STAT_PERR_BIT]));
    end
  end

  // Read pipeline: data is zeroed in any stage that carries no valid read
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        dat_pipe[i] <= '0;
      end
    end else begin
      vld_pipe[0] <= rd_acc;
      dat_pipe[0] <= rd_acc ? rd_mux : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign readdata      = dat_pipe[READ_LATENCY-1];
  assign readdatavalid = vld_pipe[READ_LATENCY-1];

endmodule

// File: tb/tb_sysid_info_slave.sv
// Bench for sysid_info_slave: two instances (read latency 1 and 2) share
// one stimulus stream and one behavioural model of the register map.
module tb_sysid_info_slave;

  localparam int unsigned CNT_W = 48;
  localparam logic [31:0] ID_V  = 32'd7;
  localparam logic [31:0] TS_V  = 32'd1381349107;
  localparam longint unsigned CNT_MASK = (64'd1 << CNT_W) - 64'd1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sysid_info_slave #(
    .ID_VALUE     (ID_V),
    .TIMESTAMP    (TS_V),
    .CNT_W        (CNT_W),
    .READ_LATENCY (1)
  ) dut1 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (rdata1),
    .readdatavalid (rvalid1)
  );

  sysid_info_slave #(
    .ID_VALUE     (ID_V),
    .TIMESTAMP    (TS_V),
    .CNT_W        (CNT_W),
    .READ_LATENCY (2)
  ) dut2 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (rdata2),
    .readdatavalid (rvalid2)
  );

  // Reference model state
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t            q1[$];
  exp_t            q2[$];
  int              ecount;
  longint unsigned m_cnt;
  logic [31:0]     m_shadow, m_scratch;
  logic            m_en, m_clr, m_lock, m_ovf, m_perr;
  bit              m_forced;
  longint unsigned m_force_val;
  logic [31:0]     cap1, cap2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_shadow = '0; m_scratch = '0;
    m_en = 1'b1; m_clr = 1'b0; m_lock = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
    q1.delete(); q2.delete();
  endtask

  function automatic logic [31:0] word_value(input logic [2:0] a);
    case (a)
      3'd0:    return ID_V;
      3'd1:    return TS_V;
      3'd2:    return 32'(m_cnt);
      3'd3:    return m_shadow;
      3'd4:    return m_scratch;
      3'd5:    return {29'd0, m_lock, 1'b0, m_en};
      3'd6:    return {30'd0, m_perr, m_ovf};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the register map, from pre-edge state and bus inputs
  task automatic model_edge();
    bit rd, wr, conflict, ovf_set, w1c;
    longint unsigned n_cnt;
    exp_t e;
    rd       = chipselect && read;
    conflict = chipselect && read && write;
    wr       = chipselect && write && !read;
    if (rd) begin
      e.data = word_value(address);
      e.due  = ecount;     q1.push_back(e);
      e.due  = ecount + 1; q2.push_back(e);
    end
    ovf_set = m_en && !m_clr && (m_cnt == CNT_MASK);
    if (m_clr)     n_cnt = 0;
    else if (m_en) n_cnt = (m_cnt + 1) & CNT_MASK;
    else           n_cnt = m_cnt;
    if (m_forced)  n_cnt = m_force_val;
    if (rd && address == 3'd2) m_shadow = 32'(m_cnt >> 32);
    w1c   = wr && address == 3'd6;
    m_ovf  = ovf_set  || (m_ovf  && !(w1c && writedata[0]));
    m_perr = conflict || (m_perr && !(w1c && writedata[1]));
    m_clr = 1'b0;
    if (wr && address == 3'd4 && !m_lock) m_scratch = writedata;
    if (wr && address == 3'd5) begin
      m_en  = writedata[0];
      m_clr = writedata[1];
      if (writedata[2]) m_lock = 1'b1;
    end
    m_cnt = n_cnt;
  endtask

  task automatic check_outputs();
    logic e1v, e2v;
    logic [31:0] e1d, e2d;
    e1v = 1'b0; e1d = '0; e2v = 1'b0; e2d = '0;
    if (q1.size() > 0 && q1[0].due == ecount) begin
      e1v = 1'b1; e1d = q1[0].data; void'(q1.pop_front());
    end
    if (q2.size() > 0 && q2[0].due == ecount) begin
      e2v = 1'b1; e2d = q2[0].data; void'(q2.pop_front());
    end
    check_eq("valid_lat1", rvalid1, e1v);
    check_eq("data_lat1",  rdata1,  e1d);
    check_eq("valid_lat2", rvalid2, e2v);
    check_eq("data_lat2",  rdata2,  e2d);
    if (rvalid1) cap1 = rdata1;
    if (rvalid2) cap2 = rdata2;
  endtask

  // One bus cycle: drive after the falling edge, model at the rising edge,
  // compare at the next falling edge
  task automatic step(input logic cs, input logic rd, input logic wr,
                      input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs; read = rd; write = wr; address = a; writedata = wd;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
    ecount++;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic wr_word(input logic [2:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, 1'b1, a, wd);
  endtask

  task automatic rd_word(input logic [2:0] a);
    cap1 = 32'hA5A5_A5A5;
    cap2 = 32'hA5A5_A5A5;
    step(1'b1, 1'b1, 1'b0, a, 32'd0);
    idle();
    idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wd;
    logic [2:0]  a;
    reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0;
    m_forced = 1'b0; m_force_val = 0; ecount = 0;
    model_reset();
    repeat (3) @(negedge clock);
    check_eq("rst_valid1", rvalid1, 1'b0);
    check_eq("rst_data1",  rdata1,  32'd0);
    check_eq("rst_valid2", rvalid2, 1'b0);
    check_eq("rst_data2",  rdata2,  32'd0);
    reset_n = 1'b1;

    // Constant words at both latencies
    rd_word(3'd0); check_eq("id_l1", cap1, 32'd7);          check_eq("id_l2", cap2, 32'd7);
    rd_word(3'd1); check_eq("ts_l1", cap1, 32'd1381349107); check_eq("ts_l2", cap2, 32'd1381349107);
    rd_word(3'd7); check_eq("w7_l1", cap1, 32'd0);          check_eq("w7_l2", cap2, 32'd0);

    // Back-to-back reads: model expects a valid on three consecutive cycles
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd1, 32'd0);
    step(1'b1, 1'b1, 1'b0, 3'd7, 32'd0);
    idle(); idle();

    // Random traffic, lock kept clear so scratch stays writable
    for (int i = 0; i < 400; i++) begin
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if (a == 3'd5) wd[2] = 1'b0;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), a, wd);
    end
    idle(); idle();

    // Scratch and read/write collision
    wr_word(3'd6, 32'h3);
    wr_word(3'd4, 32'hDEAD_BEEF);
    rd_word(3'd4); check_eq("scratch_wr", cap1, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b1, 3'd4, 32'h0000_00AA);
    idle(); idle();
    check_eq("rw_old_l1", cap1, 32'hDEAD_BEEF);
    check_eq("rw_old_l2", cap2, 32'hDEAD_BEEF);
    rd_word(3'd4); check_eq("rw_scratch", cap1, 32'hDEAD_BEEF);
    rd_word(3'd6); check_eq("perr_set",   cap1, 32'h2);
    wr_word(3'd6, 32'h2);
    rd_word(3'd6); check_eq("perr_w1c",   cap1, 32'h0);

    // HI shadow: counter held at 0x0001_FFFF_FFFF with counting disabled
    wr_word(3'd5, 32'h0);
    force dut1.u_counter.count = 48'h0001_FFFF_FFFF;
    force dut2.u_counter.count = 48'h0001_FFFF_FFFF;
    m_forced = 1'b1; m_force_val = 64'h0001_FFFF_FFFF; m_cnt = m_force_val;
    rd_word(3'd2); check_eq("uptime_lo", cap1, 32'hFFFF_FFFF); check_eq("uptime_lo2", cap2, 32'hFFFF_FFFF);
    rd_word(3'd3); check_eq("uptime_hi", cap1, 32'h1);         check_eq("uptime_hi2", cap2, 32'h1);
    rd_word(3'd3); check_eq("hi_stable", cap1, 32'h1);

    // Overflow: one enabled edge at all-ones sets ovf, W1C clears it
    force dut1.u_counter.count = 48'h0;
    force dut2.u_counter.count = 48'h0;
    m_force_val = 0; m_cnt = 0;
    wr_word(3'd5, 32'h1);
    force dut1.u_counter.count = 48'hFFFF_FFFF_FFFF;
    force dut2.u_counter.count = 48'hFFFF_FFFF_FFFF;
    m_force_val = CNT_MASK; m_cnt = CNT_MASK;
    idle();
    force dut1.u_counter.count = 48'h0;
    force dut2.u_counter.count = 48'h0;
    m_force_val = 0; m_cnt = 0;
    rd_word(3'd6); check_eq("ovf_set", cap1, 32'h1);
    wr_word(3'd6, 32'h1);
    rd_word(3'd6); check_eq("ovf_w1c", cap1, 32'h0);
    // Wrap on the same edge as the W1C write: the set wins
    force dut1.u_counter.count = 48'hFFFF_FFFF_FFFF;
    force dut2.u_counter.count = 48'hFFFF_FFFF_FFFF;
    m_force_val = CNT_MASK; m_cnt = CNT_MASK;
    wr_word(3'd6, 32'h1);
    force dut1.u_counter.count = 48'h0;
    force dut2.u_counter.count = 48'h0;
    m_force_val = 0; m_cnt = 0;
    rd_word(3'd6); check_eq("ovf_set_wins", cap1, 32'h1);
    wr_word(3'd6, 32'h1);
    wr_word(3'd5, 32'h0);
    release dut1.u_counter.count;
    release dut2.u_counter.count;
    m_forced = 1'b0;
    wr_word(3'd5, 32'h3);
    idle();
    rd_word(3'd2);
    rd_word(3'd6); check_eq("status_clean", cap1, 32'h0);

    // Lock protects scratch; lock is sticky
    wr_word(3'd5, 32'h5);
    wr_word(3'd4, 32'h1234_5678);
    rd_word(3'd4); check_eq("lock_scratch", cap1, 32'hDEAD_BEEF);
    wr_word(3'd5, 32'h1);
    rd_word(3'd5); check_eq("lock_sticky", cap1, 32'h5);

    // Reset during an in-flight read at latency 2
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = 3'd0;
    @(posedge clock);
    model_edge();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("midrst_valid1", rvalid1, 1'b0);
    check_eq("midrst_valid2", rvalid2, 1'b0);
    check_eq("midrst_data2",  rdata2,  32'd0);
    @(negedge clock);
    chipselect = 1'b0; read = 1'b0;
    check_outputs(); ecount++;
    @(negedge clock);
    check_outputs(); ecount++;
    reset_n = 1'b1;
    idle();
    rd_word(3'd2); check_eq("rst_cnt_l1", cap1, 32'h1); check_eq("rst_cnt_l2", cap2, 32'h1);
    rd_word(3'd3); check_eq("rst_shadow",  cap1, 32'h0);
    rd_word(3'd4); check_eq("rst_scratch", cap1, 32'h0);
    rd_word(3'd5); check_eq("rst_control", cap1, 32'h1);
    rd_word(3'd6); check_eq("rst_status",  cap1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
